// File: rtl/serial_magnitude_comparator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_magnitude_comparator_if : start/operand/result bundle, Rev 1.0    |
// +--------------------------------------------------------------------------+
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             a_gt_b;
   logic             a_eq_b;
   logic             a_lt_b;

   modport master (
      output start, a, b,
      input  in_ready, busy, done, a_gt_b, a_eq_b, a_lt_b
   );

   modport slave (
      input  start, a, b,
      output in_ready, busy, done, a_gt_b, a_eq_b, a_lt_b
   );
endinterface
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_magnitude_comparator : MSB-first bit-serial unsigned compare,      |
// | optional SERIAL_CMP_EARLY_EXIT_EN stops at first differing bit. Rev 1.0  |
// +--------------------------------------------------------------------------+
module serial_magnitude_comparator #(
   parameter int WIDTH = 4
) (
   input  wire                            clk,
   input  wire                            rst,
   serial_magnitude_comparator_if.slave   cmp_io
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               decided_q, decided_d;
   logic               gt_q, gt_d;
   logic               a_gt_b_q, a_gt_b_d;
   logic               a_eq_b_q, a_eq_b_d;
   logic               a_lt_b_q, a_lt_b_d;
   logic               w_bits_differ;
   logic               w_first_diff;
   logic               w_finish;

   assign w_bits_differ = sa_q[WIDTH-1] ^ sb_q[WIDTH-1];
   assign w_first_diff  = ~decided_q & w_bits_differ;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign w_finish = (cnt_q == '0) | w_first_diff;
`else
   assign w_finish = (cnt_q == '0);
`endif

   always_comb begin
      state_d   = state_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      gt_d      = gt_q;
      a_gt_b_d  = a_gt_b_q;
      a_eq_b_d  = a_eq_b_q;
      a_lt_b_d  = a_lt_b_q;

      case (state_q)
         ST_IDLE: begin
            if (cmp_io.start) begin
               sa_d      = cmp_io.a;
               sb_d      = cmp_io.b;
               cnt_d     = CNT_W'(WIDTH - 1);
               decided_d = 1'b0;
               gt_d      = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_first_diff) begin
               decided_d = 1'b1;
               gt_d      = sa_q[WIDTH-1];
            end
            sa_d  = sa_q << 1;
            sb_d  = sb_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            // Flags are loaded on the way into DONE so they are valid with the done pulse.
            if (w_finish) begin
               a_gt_b_d = decided_d & gt_d;
               a_lt_b_d = decided_d & ~gt_d;
               a_eq_b_d = ~decided_d;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sa_q      <= '0;
         sb_q      <= '0;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         gt_q      <= 1'b0;
         a_gt_b_q  <= 1'b0;
         a_eq_b_q  <= 1'b0;
         a_lt_b_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         gt_q      <= gt_d;
         a_gt_b_q  <= a_gt_b_d;
         a_eq_b_q  <= a_eq_b_d;
         a_lt_b_q  <= a_lt_b_d;
      end
   end

   assign cmp_io.in_ready = (state_q == ST_IDLE);
   assign cmp_io.busy     = (state_q != ST_IDLE);
   assign cmp_io.done     = (state_q == ST_DONE);
   assign cmp_io.a_gt_b   = a_gt_b_q;
   assign cmp_io.a_eq_b   = a_eq_b_q;
   assign cmp_io.a_lt_b   = a_lt_b_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_magnitude_comparator : directed + random bench, Rev 1.0         |
// +--------------------------------------------------------------------------+
module tb_serial_magnitude_comparator;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   serial_magnitude_comparator_if #(.WIDTH(W)) bus ();

   serial_magnitude_comparator #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .cmp_io (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Cycles from accept to done, derived from where the operands first differ.
   function automatic int model_latency(input int av, input int bv);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      int diff;
      diff = av ^ bv;
      if (diff == 0) return W + 1;
      return W - ($clog2(diff + 1) - 1) + 1;
`else
      return W + 1;
`endif
   endfunction

   function automatic int model_flags(input int av, input int bv);
      if (av > bv) return 3'b100;
      if (av == bv) return 3'b010;
      return 3'b001;
   endfunction

   function automatic int flags_obs();
      return int'({bus.a_gt_b, bus.a_eq_b, bus.a_lt_b});
   endfunction

   task automatic run_op(input int av, input int bv, input bit inject);
      int lat;
      int got;
      int exp_f;
      lat   = model_latency(av, bv);
      exp_f = model_flags(av, bv);
      got   = 0;
      check("idle_in_ready", int'(bus.in_ready), 1);
      bus.start = 1'b1;
      bus.a     = W'(av);
      bus.b     = W'(bv);
      for (int k = 1; k <= W + 4 && got == 0; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.a     = W'($urandom);
         bus.b     = W'($urandom);
         if (inject && k == 2) begin
            bus.start = 1'b1;
            bus.a     = '0;
            bus.b     = '1;
         end
         check("busy_in_ready", int'(bus.in_ready), 0);
         check("busy_flag", int'(bus.busy), 1);
         if (bus.done) got = k;
      end
      bus.start = 1'b0;
      check("latency", got, lat);
      check("flags_at_done", flags_obs(), exp_f);
      @(negedge clk);
      check("done_single_pulse", int'(bus.done), 0);
      check("ready_after_done", int'(bus.in_ready), 1);
      check("flags_held", flags_obs(), exp_f);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("reset_in_ready", int'(bus.in_ready), 1);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_flags", flags_obs(), 0);
      rst = 1'b0;
      @(negedge clk);
      check("pre_first_flags", flags_obs(), 0);

      run_op(4'b0100, 4'b0011, 1'b0);
      run_op(4'b0100, 4'b0100, 1'b0);
      run_op(4'b0011, 4'b0100, 1'b0);
      run_op(4'b1000, 4'b0111, 1'b0);
      run_op(4'b0100, 4'b0011, 1'b1);
      run_op(4'b0000, 4'b0000, 1'b0);
      run_op(4'b1111, 4'b1111, 1'b0);
      run_op(4'b0000, 4'b1111, 1'b0);
      run_op(4'b1111, 4'b0000, 1'b0);
      run_op(4'b0001, 4'b0000, 1'b0);

      for (int i = 0; i < 20; i++) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), i[0]);
      end

      // Mid-operation reset after a completed result is visible.
      run_op(4'b1000, 4'b0111, 1'b0);
      bus.start = 1'b1;
      bus.a     = 4'd4;
      bus.b     = 4'd5;
      @(negedge clk);
      bus.start = 1'b0;
      check("rst_case_busy", int'(bus.busy), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_flags", flags_obs(), 0);
      repeat (W + 2) begin
         @(negedge clk);
         check("rst_no_done", int'(bus.done), 0);
      end

      run_op(4'b0011, 4'b1100, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
